c5315_alu: RTL and testbench

Registered dual-lane 9-bit ALU with a registered side-channel, packaged as one wide input vector and one wide output vector. It sits behind the pattern-application logic used for serial fault simulation. Two copies, fault-free and faulty, are driven with identical vectors and their output vectors are compared bit-for-bit. The block computes two independent 9-bit arithmetic/logic results with flags and forwards a 97-bit side-channel word, all captured in output registers.

---
 rtl/c5315_alu.sv | 83 ++++++++
 tb/tb_c5315_alu.sv | 137 +++++++++++++
 2 files changed

// File: rtl/c5315_alu.sv
// Registered dual-lane 9-bit ALU with flags and an inverting 97-bit side-channel.
// All outputs come straight from the 123 output flops; hold freezes every one of them.
module c5315_alu (
  input  logic         clk,
  input  logic         rst,
  input  logic [177:0] pi,
  output logic [122:0] po
);

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_AND   = 3'b010;
  localparam logic [2:0] OP_OR    = 3'b011;
  localparam logic [2:0] OP_XOR   = 3'b100;
  localparam logic [2:0] OP_NOTA  = 3'b101;
  localparam logic [2:0] OP_PASSA = 3'b110;
  localparam logic [2:0] OP_PASSB = 3'b111;

  // Packed as {ovf, par, zero, cout, y}, matching the per-lane po layout.
  function automatic logic [12:0] lane_eval(
    input logic [8:0] a,
    input logic [8:0] b,
    input logic [2:0] op,
    input logic       cin
  );
    logic [9:0] sum;
    logic [8:0] y;
    logic       cout;
    logic       ovf;
    sum  = 10'd0;
    y    = 9'd0;
    cout = 1'b0;
    ovf  = 1'b0;
    case (op)
      OP_ADD: begin
        sum  = {1'b0, a} + {1'b0, b} + {9'd0, cin};
        y    = sum[8:0];
        cout = sum[9];
        ovf  = (a[8] == b[8]) && (y[8] != a[8]);
      end
      OP_SUB: begin
        // a + ~b + cin; cout=1 means no borrow.
        sum  = {1'b0, a} + {1'b0, ~b} + {9'd0, cin};
        y    = sum[8:0];
        cout = sum[9];
        ovf  = (a[8] != b[8]) && (y[8] != a[8]);
      end
      OP_AND:   y = a & b;
      OP_OR:    y = a | b;
      OP_XOR:   y = a ^ b;
      OP_NOTA:  y = ~a;
      OP_PASSA: y = a;
      OP_PASSB: y = b;
      default:  y = 9'd0;
    endcase
    return {ovf, ^y, (y == 9'd0), cout, y};
  endfunction

  logic [12:0]  lane0_next;
  logic [12:0]  lane1_next;
  logic [96:0]  so_next;
  logic [122:0] po_next;
  logic         unused_bits;

  always_comb begin
    lane0_next = lane_eval(pi[8:0],   pi[17:9],  pi[20:18], pi[21]);
    lane1_next = lane_eval(pi[30:22], pi[39:31], pi[42:40], pi[43]);
    so_next    = pi[142] ? ~pi[140:44] : pi[140:44];
    po_next    = {so_next, lane1_next, lane0_next};
  end

  // Legacy vector positions with no function in this block.
  assign unused_bits = ^pi[177:143];

  always_ff @(posedge clk) begin
    if (rst) begin
      po <= '0;
    end else if (!pi[141]) begin
      po <= po_next;
    end
  end

endmodule

// File: tb/tb_c5315_alu.sv
// Directed bench for c5315_alu: hand-computed expected output vectors, checked
// one clock after each input vector is applied.
module tb_c5315_alu;

  logic         clk;
  logic         rst;
  logic [177:0] pi;
  logic [122:0] po;

  int checks;
  int failures;

  c5315_alu dut (
    .clk (clk),
    .rst (rst),
    .pi  (pi),
    .po  (po)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [177:0] mk_pi(
    input logic [8:0]  a0, input logic [8:0] b0, input logic [2:0] op0, input logic cin0,
    input logic [8:0]  a1, input logic [8:0] b1, input logic [2:0] op1, input logic cin1,
    input logic [96:0] sc, input logic hold, input logic inv, input logic [34:0] junk
  );
    return {junk, inv, hold, sc, cin1, op1, b1, a1, cin0, op0, b0, a0};
  endfunction

  function automatic logic [122:0] mk_po(
    input logic [8:0] y0, input logic c0, input logic z0, input logic p0, input logic o0,
    input logic [8:0] y1, input logic c1, input logic z1, input logic p1, input logic o1,
    input logic [96:0] so
  );
    return {so, o1, p1, z1, c1, y1, o0, p0, z0, c0, y0};
  endfunction

  function automatic logic [177:0] rand_pi();
    logic [191:0] r;
    for (int i = 0; i < 6; i++) r[i*32 +: 32] = $urandom;
    return r[177:0];
  endfunction

  // Apply a vector, let one rising edge capture it, sample 1 time unit later.
  task automatic step(input logic r, input logic [177:0] v);
    rst = r;
    pi  = v;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [122:0] obs, input logic [122:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  localparam logic [96:0] SC = 97'h1_2345_6789_ABCD_EF01_2345_6789;

  logic [8:0]   logic_y   [6];
  logic         logic_par [6];
  logic [122:0] held;
  logic [177:0] v;

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    pi       = '0;
    logic_y   = '{9'h050, 9'h1F5, 9'h1A5, 9'h0AA, 9'h155, 9'h0F0};
    logic_par = '{1'b0,   1'b1,   1'b1,   1'b0,   1'b1,   1'b0};
    @(negedge clk);

    // Reset with random inputs, then hold from reset.
    step(1'b1, rand_pi());
    check("reset", po, '0);
    v = rand_pi();
    v[141] = 1'b1;
    step(1'b0, v);
    check("hold_after_reset", po, '0);

    // Lane 0 ADD overflow, lane 1 SUB equal operands.
    step(1'b0, mk_pi(9'h0FF, 9'h001, 3'b000, 1'b0, 9'd5, 9'd5, 3'b001, 1'b1,
                     '0, 1'b0, 1'b0, '0));
    check("add_ovf_sub_eq", po,
          mk_po(9'h100, 1'b0, 1'b0, 1'b1, 1'b1, 9'h000, 1'b1, 1'b1, 1'b0, 1'b0, '0));

    // Lane 0 logic sweep while lane 1 does the ADD carry wrap.
    for (int k = 0; k < 6; k++) begin
      step(1'b0, mk_pi(9'h155, 9'h0F0, 3'(k + 2), 1'b1, 9'h1FF, 9'h001, 3'b000, 1'b0,
                       '0, 1'b0, 1'b0, '0));
      check($sformatf("logic_op%0d_wrap", k + 2), po,
            mk_po(logic_y[k], 1'b0, 1'b0, logic_par[k], 1'b0,
                  9'h000, 1'b1, 1'b1, 1'b0, 1'b0, '0));
    end

    // Lane 0 negative ADD overflow to zero, lane 1 SUB with borrow; side-channel straight.
    step(1'b0, mk_pi(9'h100, 9'h100, 3'b000, 1'b0, 9'd3, 9'd5, 3'b001, 1'b1,
                     SC, 1'b0, 1'b0, '0));
    check("sc_pass", po,
          mk_po(9'h000, 1'b1, 1'b1, 1'b0, 1'b1, 9'h1FE, 1'b0, 1'b0, 1'b0, 1'b0, SC));

    v = mk_pi(9'h100, 9'h100, 3'b000, 1'b0, 9'd3, 9'd5, 3'b001, 1'b1,
              SC, 1'b0, 1'b1, '0);
    step(1'b0, v);
    held = mk_po(9'h000, 1'b1, 1'b1, 1'b0, 1'b1, 9'h1FE, 1'b0, 1'b0, 1'b0, 1'b0, ~SC);
    check("sc_invert", po, held);

    // Hold with every field and both ops changed.
    step(1'b0, mk_pi(9'h0AA, 9'h033, 3'b100, 1'b1, 9'h011, 9'h1C0, 3'b011, 1'b0,
                     ~SC, 1'b1, 1'b0, 35'h5_A5A5_A5A5));
    check("hold_all_changed", po, held);

    // Only the ignored bits differ from the last loaded vector.
    v[177:143] = ~v[177:143];
    step(1'b0, v);
    check("ignored_bits", po, held);

    // Reset overrides hold mid-stream.
    v[141] = 1'b1;
    step(1'b1, v);
    check("reset_over_hold", po, '0);

    // First result after reset: SUB 0-1 without carry-in, ADD overflow with odd parity.
    step(1'b0, mk_pi(9'h000, 9'h001, 3'b001, 1'b0, 9'h0FF, 9'h0FF, 3'b000, 1'b1,
                     97'h1, 1'b0, 1'b0, '0));
    check("post_reset", po,
          mk_po(9'h1FE, 1'b0, 1'b0, 1'b0, 1'b0, 9'h1FF, 1'b0, 1'b0, 1'b1, 1'b1, 97'h1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
